// File: rtl/jtframe_joyser_tx_pkg.sv
// Shared definitions for the DB9 joystick shift-register link: pad bit indices,
// the order fields go out on the wire, FSM encoding and the frame-word builder.
package jtframe_joyser_tx_pkg;

    localparam logic [2:0] JOY_R  = 3'd0;
    localparam logic [2:0] JOY_L  = 3'd1;
    localparam logic [2:0] JOY_D  = 3'd2;
    localparam logic [2:0] JOY_U  = 3'd3;
    localparam logic [2:0] JOY_F1 = 3'd4;
    localparam logic [2:0] JOY_F2 = 3'd5;

    localparam int FRAME_W = 16;
    localparam int FIELD_W = 6;

    // Wire order of one player field, first entry goes out first
    localparam logic [2:0] FRAME_ORDER [FIELD_W] = '{JOY_F2, JOY_F1, JOY_R, JOY_L, JOY_D, JOY_U};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic logic [FIELD_W-1:0] field_bits(input logic [FIELD_W-1:0] p);
        return {p[FRAME_ORDER[0]], p[FRAME_ORDER[1]], p[FRAME_ORDER[2]],
                p[FRAME_ORDER[3]], p[FRAME_ORDER[4]], p[FRAME_ORDER[5]]};
    endfunction

    // Pressed buttons are placed active-high then inverted, so every filler bit ends up 1
    function automatic logic [FRAME_W-1:0] frame_word(input logic [FIELD_W-1:0] p1,
                                                      input logic [FIELD_W-1:0] p2,
                                                      input int unsigned pad_bits);
        logic [FRAME_W-1:0] pressed;
        pressed = {field_bits(p1), field_bits(p2), 4'b0000} >> pad_bits;
        return ~pressed;
    endfunction

endpackage

// File: rtl/jtframe_joyser_tx_if.sv
// Host-side serial link of the joystick shift-register chain.
interface jtframe_joyser_tx_if;
    logic joy_clk;
    logic joy_load;
    logic joy_data;

    modport master (output joy_clk, output joy_load, input  joy_data);
    modport slave  (input  joy_clk, input  joy_load, output joy_data);
endinterface

// File: rtl/jtframe_sync_edge.sv
// Multi-stage synchroniser for an asynchronous pin with rise/fall detection
// against one extra flop behind the last stage.
module jtframe_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic [STAGES-1:0] r_sync;
    logic              r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {STAGES{RST_VAL}};
            r_last <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_last <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  =  r_sync[STAGES-1] & ~r_last;
    assign o_fall  = ~r_sync[STAGES-1] &  r_last;
endmodule

// File: rtl/jtframe_joyser_tx.sv
// Emulates the 74HC165 chain polled by the DB9 joystick reader: captures both pads
// while load is low and shifts the frame out MSB-first on host clock rises.
module jtframe_joyser_tx
    import jtframe_joyser_tx_pkg::*;
#(
    parameter int SYNC_STG = 2,
    parameter int PAD_BITS = 2,
    parameter int TOUT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    jtframe_joyser_tx_if.slave   joy,
    input  logic [FIELD_W-1:0]   pad1,
    input  logic [FIELD_W-1:0]   pad2,
    output logic                 frame_done,
    output logic                 overrun,
    output logic                 link_ok
);
    if (PAD_BITS < 0 || PAD_BITS + 2*FIELD_W > FRAME_W) begin : g_bad_pad_bits
        $error("PAD_BITS must keep both fields inside the 16-bit frame");
    end
    if (SYNC_STG < 2) begin : g_bad_sync_stg
        $error("SYNC_STG must be at least 2");
    end

    logic w_jclk_lvl, w_jclk_rise, w_jclk_fall;
    logic w_load_lvl, w_load_rise, w_load_fall;
    logic w_unused;

    jtframe_sync_edge #(.STAGES(SYNC_STG), .RST_VAL(1'b0)) u_sync_clk (
        .clk     (clk),
        .rst     (rst),
        .i_async (joy.joy_clk),
        .o_level (w_jclk_lvl),
        .o_rise  (w_jclk_rise),
        .o_fall  (w_jclk_fall)
    );

    // Load idles high, so its synchroniser resets high to avoid a phantom load edge
    jtframe_sync_edge #(.STAGES(SYNC_STG), .RST_VAL(1'b1)) u_sync_load (
        .clk     (clk),
        .rst     (rst),
        .i_async (joy.joy_load),
        .o_level (w_load_lvl),
        .o_rise  (w_load_rise),
        .o_fall  (w_load_fall)
    );

    assign w_unused = &{1'b0, w_jclk_lvl, w_jclk_fall, w_load_rise};

    logic [1:0]         r_state;
    logic [FRAME_W-1:0] r_shift;
    logic [3:0]         r_bit_cnt;
    logic [TOUT_W-1:0]  r_wd_cnt;
    logic               r_frame_done;
    logic               r_overrun;
    logic               r_link_ok;
    logic               w_wd_full;
    logic               w_wd_expire;

    assign w_wd_full   = &r_wd_cnt;
    assign w_wd_expire = w_wd_full & ~w_load_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_shift      <= '1;
            r_bit_cnt    <= 4'd0;
            r_wd_cnt     <= '0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
            r_link_ok    <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;

            // Watchdog saturates instead of wrapping, so a dead host stays flagged
            if (w_load_fall) begin
                r_wd_cnt  <= '0;
                r_link_ok <= 1'b1;
            end else if (!w_wd_full) begin
                r_wd_cnt  <= r_wd_cnt + 1'b1;
            end else begin
                r_link_ok <= 1'b0;
            end

            if (w_wd_expire) begin
                r_state <= ST_IDLE;
            end else if (!w_load_lvl) begin
                // Transparent parallel load, outranking any shift clock
                r_state   <= ST_LOAD;
                r_shift   <= frame_word(pad1, pad2, PAD_BITS);
                r_bit_cnt <= 4'd0;
                r_overrun <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: r_state <= ST_IDLE;
                    ST_LOAD: r_state <= ST_SHIFT;
                    ST_SHIFT: begin
                        if (w_jclk_rise) begin
                            r_shift   <= {r_shift[FRAME_W-2:0], 1'b1};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'd15) begin
                                r_state      <= ST_DONE;
                                r_frame_done <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (w_jclk_rise) begin
                            r_overrun <= 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign joy.joy_data = (r_state == ST_LOAD || r_state == ST_SHIFT) ? r_shift[FRAME_W-1] : 1'b1;
    assign frame_done   = r_frame_done;
    assign overrun      = r_overrun;
    assign link_ok      = r_link_ok;
endmodule

// File: tb/tb_jtframe_joyser_tx.sv
// Directed bench for the joystick shift-register responder: acts as the host
// reader, samples each bit before its clock rise and checks against hand-built frames.
module tb_jtframe_joyser_tx;
    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] pad1, pad2, padw;
    logic       frame_done, overrun, link_ok;
    logic       frame_done_w, overrun_w, link_ok_w;

    jtframe_joyser_tx_if ifc ();
    jtframe_joyser_tx_if ifw ();

    jtframe_joyser_tx #(.SYNC_STG(2), .PAD_BITS(2), .TOUT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .joy        (ifc),
        .pad1       (pad1),
        .pad2       (pad2),
        .frame_done (frame_done),
        .overrun    (overrun),
        .link_ok    (link_ok)
    );

    // Short watchdog instance for the link-loss timing
    jtframe_joyser_tx #(.SYNC_STG(2), .PAD_BITS(2), .TOUT_W(8)) dut_wd (
        .clk        (clk),
        .rst        (rst),
        .joy        (ifw),
        .pad1       (padw),
        .pad2       (padw),
        .frame_done (frame_done_w),
        .overrun    (overrun_w),
        .link_ok    (link_ok_w)
    );

    always #5 clk = ~clk;

    int          n_vec  = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    int          d0;
    logic [15:0] rx;

    always @(posedge clk) begin
        if (frame_done) done_cnt <= done_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("vec %0d %s: observed %0h expected %0h", n_vec, tag, obs, exp);
    endtask

    task automatic load_pulse();
        ifc.joy_load = 1'b0;
        tick(64);
        ifc.joy_load = 1'b1;
        tick(8);
    endtask

    // Sample the presented bit, then give one clk/64 shift clock
    task automatic read_bits(input int n);
        for (int i = 0; i < n; i++) begin
            rx = {rx[14:0], ifc.joy_data};
            ifc.joy_clk = 1'b1;
            tick(32);
            ifc.joy_clk = 1'b0;
            tick(32);
        end
    endtask

    initial begin
        rst = 1'b1;
        ifc.joy_clk = 1'b0;  ifc.joy_load = 1'b1;
        ifw.joy_clk = 1'b0;  ifw.joy_load = 1'b1;
        pad1 = 6'd0;  pad2 = 6'd0;  padw = 6'd0;
        rx = 16'd0;

        // 1: reset state
        tick(3);
        check("rst_joy_data",   32'(ifc.joy_data), 32'd1);
        check("rst_link_ok",    32'(link_ok),      32'd0);
        check("rst_overrun",    32'(overrun),      32'd0);
        check("rst_frame_done", 32'(frame_done),   32'd0);
        rst = 1'b0;
        tick(4);

        // 2: F1+R on player 1, with a latency probe on the third shift clock
        pad1 = 6'b010001;  pad2 = 6'b000000;
        d0 = done_cnt;
        load_pulse();
        check("t2_link_ok", 32'(link_ok), 32'd1);
        rx = 16'd0;
        read_bits(2);
        rx = {rx[14:0], ifc.joy_data};
        ifc.joy_clk = 1'b1;
        tick(2);
        check("t2_lat_2clk", 32'(ifc.joy_data), 32'd1);
        tick(1);
        check("t2_lat_3clk", 32'(ifc.joy_data), 32'd0);
        tick(29);
        ifc.joy_clk = 1'b0;
        tick(32);
        read_bits(13);
        check("t2_word", 32'(rx), 32'h0000_E7FF);
        check("t2_done_pulses", 32'(done_cnt - d0), 32'd1);

        // 5: clock past the end of the frame
        check("t5_overrun_pre", 32'(overrun), 32'd0);
        ifc.joy_clk = 1'b1;
        tick(32);
        ifc.joy_clk = 1'b0;
        tick(32);
        check("t5_overrun", 32'(overrun), 32'd1);
        check("t5_joy_data", 32'(ifc.joy_data), 32'd1);

        // 3: F2+D on player 2; pad change mid-frame must not reach the wire
        pad1 = 6'b000000;  pad2 = 6'b100100;
        d0 = done_cnt;
        load_pulse();
        check("t3_overrun_clr", 32'(overrun), 32'd0);
        pad2 = 6'b000000;
        rx = 16'd0;
        read_bits(16);
        check("t3_word", 32'(rx), 32'h0000_FF77);
        check("t3_done_pulses", 32'(done_cnt - d0), 32'd1);

        // 4: abort after 7 bits, reload with new pads
        pad1 = 6'b010001;  pad2 = 6'b000000;
        d0 = done_cnt;
        load_pulse();
        rx = 16'd0;
        read_bits(7);
        check("t4_partial", 32'(rx[6:0]), 32'h73);
        pad1 = 6'b001010;  pad2 = 6'b000001;
        load_pulse();
        check("t4_no_done", 32'(done_cnt - d0), 32'd0);
        rx = 16'd0;
        read_bits(16);
        check("t4_word", 32'(rx), 32'h0000_FADF);
        check("t4_done_pulses", 32'(done_cnt - d0), 32'd1);

        // 6: watchdog with 8-bit counter; load pin falls, sync fall seen 3 clocks later
        check("t6_expired", 32'(link_ok_w), 32'd0);
        ifw.joy_load = 1'b0;
        tick(3);
        check("t6_link_up", 32'(link_ok_w), 32'd1);
        ifw.joy_load = 1'b1;
        tick(255);
        check("t6_at_255", 32'(link_ok_w), 32'd1);
        tick(1);
        check("t6_at_256", 32'(link_ok_w), 32'd0);
        ifw.joy_load = 1'b0;
        tick(3);
        check("t6_restored", 32'(link_ok_w), 32'd1);
        ifw.joy_load = 1'b1;
        tick(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
